// File: rtl/memory_pkg.sv
// Shared constants, cell encoding and helpers for the Connect-4 board store.
package memory_pkg;

    localparam int ROWS      = 32;
    localparam int COLS      = 8;
    localparam int CELL_W    = 2;
    localparam int WIN       = 4;
    localparam int ROW_W     = 16;
    localparam int BANK_ROWS = ROWS / 2;
    localparam int WIN_W     = WIN * ROW_W;

    typedef enum logic [CELL_W-1:0] {
        EMPTY = 2'b00,
        P0    = 2'b01,
        P1    = 2'b10
    } cell_e;

    function automatic cell_e player_cell(input logic player);
        return player ? P1 : P0;
    endfunction

endpackage

// File: rtl/memory_window_mux.sv
// Selects a WIN-row vertical window from one 16-row bank, wrapping modulo 16.
module memory_window_mux
    import memory_pkg::*;
(
    input  logic [BANK_ROWS-1:0][ROW_W-1:0] rows,
    input  logic [3:0]                      top_row,
    output logic [WIN_W-1:0]                window
);

    logic [3:0] idx;

    // Newest (top) row lands in the most significant slice; 4-bit subtraction gives the wrap.
    always_comb begin
        window = '0;
        idx    = '0;
        for (int k = 0; k < WIN; k++) begin
            idx = top_row - 4'(k);
            window[(WIN-1-k)*ROW_W +: ROW_W] = rows[idx];
        end
    end

endmodule

// File: rtl/memory.sv
// Connect-4 board storage: single-cell token writes, dual-bank 4-row window reads.
module memory
    import memory_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wen,
    input  logic             ren,
    input  logic             Player,
    input  logic [2:0]       colval,
    input  logic [4:0]       waddr,
    input  logic [4:0]       rdaddr,
    output logic [WIN_W-1:0] Hdataline,
    output logic [WIN_W-1:0] Ldataline
);

    logic [ROWS-1:0][ROW_W-1:0] board_q, board_d;
    logic [WIN_W-1:0]           hdata_q, hdata_d;
    logic [WIN_W-1:0]           ldata_q, ldata_d;
    logic [WIN_W-1:0]           h_window, l_window;
    logic [3:0]                 cell_lsb;
    logic                       unused_rdaddr_msb;

    // rdaddr[4] is reserved: both banks always use the same 4-bit window index.
    assign unused_rdaddr_msb = rdaddr[4];
    assign cell_lsb          = {colval, 1'b0};

    memory_window_mux u_bank0_mux (
        .rows    (board_q[BANK_ROWS-1:0]),
        .top_row (rdaddr[3:0]),
        .window  (h_window)
    );

    memory_window_mux u_bank1_mux (
        .rows    (board_q[ROWS-1:BANK_ROWS]),
        .top_row (rdaddr[3:0]),
        .window  (l_window)
    );

    // Windows come from board_q, so a same-edge write is only visible to later reads.
    always_comb begin
        board_d = board_q;
        hdata_d = hdata_q;
        ldata_d = ldata_q;
        if (wen) begin
            board_d[waddr][cell_lsb +: CELL_W] = player_cell(Player);
        end
        if (ren) begin
            hdata_d = h_window;
            ldata_d = l_window;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            board_q <= '0;
            hdata_q <= '0;
            ldata_q <= '0;
        end else begin
            board_q <= board_d;
            hdata_q <= hdata_d;
            ldata_q <= ldata_d;
        end
    end

    assign Hdataline = hdata_q;
    assign Ldataline = ldata_q;

endmodule

// File: tb/tb_memory.sv
// Directed self-checking bench for the Connect-4 board store.
module tb_memory;

    logic        clk;
    logic        rst_n;
    logic        wen;
    logic        ren;
    logic        Player;
    logic [2:0]  colval;
    logic [4:0]  waddr;
    logic [4:0]  rdaddr;
    logic [63:0] Hdataline;
    logic [63:0] Ldataline;

    int testCount;
    int failCount;

    memory dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wen       (wen),
        .ren       (ren),
        .Player    (Player),
        .colval    (colval),
        .waddr     (waddr),
        .rdaddr    (rdaddr),
        .Hdataline (Hdataline),
        .Ldataline (Ldataline)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic w, input logic r, input logic p,
                                 input logic [2:0] c, input logic [4:0] wa,
                                 input logic [4:0] ra);
        @(negedge clk);
        wen    = w;
        ren    = r;
        Player = p;
        colval = c;
        waddr  = wa;
        rdaddr = ra;
        @(posedge clk);
        #1;
        wen = 1'b0;
        ren = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] expH,
                               input logic [63:0] expL);
        testCount++;
        assert (Hdataline === expH) else begin
            failCount++;
            $error("[TB] FAIL %s Hdataline observed=%h expected=%h", tag, Hdataline, expH);
        end
        testCount++;
        assert (Ldataline === expL) else begin
            failCount++;
            $error("[TB] FAIL %s Ldataline observed=%h expected=%h", tag, Ldataline, expL);
        end
    endtask

    initial begin
        testCount = 0;
        failCount = 0;
        rst_n  = 1'b0;
        wen    = 1'b0;
        ren    = 1'b0;
        Player = 1'b0;
        colval = 3'd0;
        waddr  = 5'd0;
        rdaddr = 5'd0;

        #12;
        checkOutput("reset_state", 64'h0, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(0, 1, 0, 3'd0, 5'd0, 5'b01111);
        checkOutput("read_empty", 64'h0, 64'h0);

        applyStimulus(1, 0, 1, 3'd2, 5'd31, 5'd0);
        checkOutput("write_no_read_hold", 64'h0, 64'h0);
        applyStimulus(0, 1, 0, 3'd0, 5'd0, 5'b01111);
        checkOutput("read_row31", 64'h0, 64'h0020_0000_0000_0000);

        applyStimulus(0, 0, 0, 3'd0, 5'd0, 5'b01110);
        checkOutput("hold_ren0", 64'h0, 64'h0020_0000_0000_0000);

        applyStimulus(0, 1, 0, 3'd0, 5'd0, 5'b01110);
        checkOutput("read_rd14", 64'h0, 64'h0);
        applyStimulus(0, 1, 0, 3'd0, 5'd0, 5'b01101);
        checkOutput("read_rd13", 64'h0, 64'h0);
        applyStimulus(0, 1, 0, 3'd0, 5'd0, 5'b01100);
        checkOutput("read_rd12", 64'h0, 64'h0);

        applyStimulus(1, 0, 0, 3'd2, 5'd7, 5'd0);
        applyStimulus(1, 0, 0, 3'd7, 5'd7, 5'd0);
        applyStimulus(0, 1, 0, 3'd0, 5'd0, 5'b00111);
        checkOutput("read_row7", 64'h4010_0000_0000_0000, 64'h0);

        applyStimulus(1, 0, 1, 3'd0, 5'd14, 5'd0);
        applyStimulus(0, 1, 0, 3'd0, 5'd0, 5'b00001);
        checkOutput("wrap_rd1", 64'h0000_0000_0000_0002, 64'h0000_0000_0020_0000);

        applyStimulus(1, 0, 1, 3'd2, 5'd7, 5'd0);
        applyStimulus(0, 1, 0, 3'd0, 5'd0, 5'b01010);
        checkOutput("overwrite_row7", 64'h0000_0000_0000_4020, 64'h0);

        applyStimulus(0, 1, 0, 3'd0, 5'd0, 5'b10111);
        checkOutput("rdaddr_msb_ignored", 64'h4020_0000_0000_0000, 64'h0);

        applyStimulus(1, 1, 0, 3'd0, 5'd31, 5'b01111);
        checkOutput("same_edge_old", 64'h0000_0002_0000_0000, 64'h0020_0000_0000_0000);
        applyStimulus(0, 1, 0, 3'd0, 5'd0, 5'b01111);
        checkOutput("same_edge_new", 64'h0000_0002_0000_0000, 64'h0021_0000_0000_0000);

        @(negedge clk);
        wen    = 1'b1;
        ren    = 1'b1;
        Player = 1'b1;
        colval = 3'd0;
        waddr  = 5'd0;
        rdaddr = 5'b00011;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_clear", 64'h0, 64'h0);
        @(posedge clk);
        #1;
        checkOutput("reset_held", 64'h0, 64'h0);
        @(negedge clk);
        wen   = 1'b0;
        ren   = 1'b0;
        rst_n = 1'b1;

        applyStimulus(0, 1, 0, 3'd0, 5'd0, 5'b00011);
        checkOutput("write_discarded", 64'h0, 64'h0);
        applyStimulus(0, 1, 0, 3'd0, 5'd0, 5'b01111);
        checkOutput("board_cleared", 64'h0, 64'h0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
